turn_input_cond: RTL and testbench

Input conditioner that sits directly upstream of the turn-signal FSM. It takes the raw, asynchronous left/right turn switches and synchronizes and debounces each one. It also generates a periodic single-cycle `tick` clock-enable, and presents clean `l`/`r` levels that change only on `tick` cycles. The FSM advances on `tick` and therefore never sees a switch change partway through a step.

---
 rtl/turn_input_cond.sv | 141 ++++++++++++++
 tb/tb_turn_input_cond.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/turn_input_cond.sv
// rtl/turn_input_cond.sv - switch synchronizer, debouncer and tick-aligned output stage for the turn-signal FSM
//
// Purpose:
//   Conditions the raw left/right turn switches for the downstream turn-signal
//   FSM. Each switch is synchronized with two flops and then debounced. The
//   block also generates a periodic one-cycle step enable (tick). The clean
//   levels presented to the FSM change only on tick edges, so the FSM never
//   sees a switch change partway through a step.
//
// Ports (turn_input_cond):
//   i_clk    in   1  system clock, rising edge
//   i_reset  in   1  synchronous active-high reset, clears all state
//   i_raw_l  in   1  left switch, asynchronous, may bounce
//   i_raw_r  in   1  right switch, asynchronous, may bounce
//   o_l      out  1  conditioned left request, registered, updates on tick
//   o_r      out  1  conditioned right request, registered, updates on tick
//   o_tick   out  1  one-cycle step enable, period TICK_DIV
//
// Ports (turn_input_cond_chan):
//   i_clk    in   1  system clock
//   i_reset  in   1  synchronous active-high reset
//   i_raw    in   1  raw asynchronous switch
//   o_db     out  1  debounced level

module turn_input_cond_chan #(
  parameter int DB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_db
);

  localparam int             CW       = $clog2(DB_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  // The debouncer's STABLE/COUNTING state is implied by (r_s2 != r_db);
  // keeping it implicit means a return to agreement discards the partial
  // count on the very same edge, with no extra state flop to keep in step.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // DB_CYCLES consecutive edges of disagreement: accept the new level.
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_db = r_db;

endmodule

module turn_input_cond #(
  parameter int DB_CYCLES = 4,
  parameter int TICK_DIV  = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw_l,
  input  logic i_raw_r,
  output logic o_l,
  output logic o_r,
  output logic o_tick
);

  localparam int            DW       = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic          w_db_l;
  logic          w_db_r;
  logic          w_tick;
  logic [DW-1:0] r_div;
  logic          r_l;
  logic          r_r;

  turn_input_cond_chan #(
    .DB_CYCLES (DB_CYCLES)
  ) u_chan_l (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_raw   (i_raw_l),
    .o_db    (w_db_l)
  );

  turn_input_cond_chan #(
    .DB_CYCLES (DB_CYCLES)
  ) u_chan_r (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_raw   (i_raw_r),
    .o_db    (w_db_r)
  );

  // Free-running step divider; tick is a pure decode of the registered count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div <= '0;
    end else if (r_div == DIV_LAST) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  assign w_tick = (r_div == DIV_LAST);

  // Both channels are captured on the same tick edge so simultaneous presses
  // reach the FSM together. A debounced flip landing on the tick edge itself
  // is picked up at the following tick.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_l <= 1'b0;
      r_r <= 1'b0;
    end else if (w_tick) begin
      r_l <= w_db_l;
      r_r <= w_db_r;
    end
  end

  assign o_l    = r_l;
  assign o_r    = r_r;
  assign o_tick = w_tick;

endmodule

// File: tb/tb_turn_input_cond.sv
// tb/tb_turn_input_cond.sv - scoreboard bench for turn_input_cond against a windowed behavioural model

module tb_turn_input_cond;

  localparam int DB = 4;
  localparam int TD = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic raw_l = 1'b1;
  logic raw_r = 1'b1;
  logic o_l;
  logic o_r;
  logic o_tick;

  always #5 clk = ~clk;

  turn_input_cond #(
    .DB_CYCLES (DB),
    .TICK_DIV  (TD)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_raw_l (raw_l),
    .i_raw_r (raw_r),
    .o_l     (o_l),
    .o_r     (o_r),
    .o_tick  (o_tick)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit started  = 1'b0;

  // Expected {tick, l, r} for the cycle following each rising edge.
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic act, input logic want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, want);
  endtask

  // Reference model. Raw samples are kept as a short history so the
  // synchronized value is simply the raw value from two edges ago; the
  // debounced level flips when the last DB synchronized samples all disagree
  // with it. Tick phase is the count of edges since reset modulo TD.
  logic hist_l[$];
  logic hist_r[$];
  logic seq_l[$];
  logic seq_r[$];
  logic m_db_l, m_db_r, m_out_l, m_out_r;
  int   m_k;

  always @(posedge clk) begin
    logic s2l, s2r;
    bit   flip;
    if (reset) begin
      hist_l = {1'b0, 1'b0};
      hist_r = {1'b0, 1'b0};
      seq_l.delete();
      seq_r.delete();
      m_db_l  = 1'b0;
      m_db_r  = 1'b0;
      m_out_l = 1'b0;
      m_out_r = 1'b0;
      m_k     = 0;
      exp_q.push_back(3'b000);
    end else begin
      s2l = hist_l[0];
      s2r = hist_r[0];
      hist_l.push_back(raw_l);
      hist_l.pop_front();
      hist_r.push_back(raw_r);
      hist_r.pop_front();
      if (m_k % TD == TD - 1) begin
        m_out_l = m_db_l;
        m_out_r = m_db_r;
      end
      seq_l.push_back(s2l);
      if (seq_l.size() > DB) void'(seq_l.pop_front());
      seq_r.push_back(s2r);
      if (seq_r.size() > DB) void'(seq_r.pop_front());
      if (seq_l.size() == DB) begin
        flip = 1'b1;
        foreach (seq_l[i]) if (seq_l[i] == m_db_l) flip = 1'b0;
        if (flip) m_db_l = ~m_db_l;
      end
      if (seq_r.size() == DB) begin
        flip = 1'b1;
        foreach (seq_r[i]) if (seq_r[i] == m_db_r) flip = 1'b0;
        if (flip) m_db_r = ~m_db_r;
      end
      m_k++;
      exp_q.push_back({(m_k % TD == TD - 1), m_out_l, m_out_r});
    end
    started = 1'b1;
  end

  // Monitor: the DUT presents a {tick, l, r} sample every cycle.
  always @(negedge clk) begin
    logic [2:0] e;
    cyc++;
    if (started) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty cyc=%0d got=0 entries want>=1", cyc);
      end else begin
        e = exp_q.pop_front();
        check("tick", o_tick, e[2]);
        check("l", o_l, e[1]);
        check("r", o_r, e[0]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    step(n);
    reset = 1'b0;
  endtask

  initial begin
    int len_l, len_r;
    int bounce[5];
    bounce = '{1, 0, 1, 1, 0};

    // Reset with both switches held high, then watch the tick cadence.
    step(2);
    reset = 1'b0;
    step(24);
    raw_l = 1'b0;
    raw_r = 1'b0;
    step(24);

    // Glitch shorter than the debounce window.
    raw_l = 1'b1;
    step(3);
    raw_l = 1'b0;
    step(30);

    // Clean press and release on left.
    raw_l = 1'b1;
    step(30);
    raw_l = 1'b0;
    step(30);

    // Bouncing press on right.
    for (int i = 0; i < 5; i++) begin
      raw_r = bounce[i][0];
      step(1);
    end
    raw_r = 1'b1;
    step(30);
    raw_r = 1'b0;
    step(30);

    // Hazard: both together, then both released together.
    raw_l = 1'b1;
    raw_r = 1'b1;
    step(30);
    raw_l = 1'b0;
    raw_r = 1'b0;
    step(30);

    // Reset three cycles into a press.
    raw_l = 1'b1;
    step(3);
    do_reset(2);
    step(30);
    raw_l = 1'b0;
    step(20);

    // Randomized switch activity with bounce-like run lengths and occasional resets.
    len_l = 1;
    len_r = 1;
    for (int c = 0; c < 3000; c++) begin
      if (--len_l == 0) begin
        raw_l = ~raw_l;
        len_l = $urandom_range(1, 12);
      end
      if (--len_r == 0) begin
        raw_r = ~raw_r;
        len_r = $urandom_range(1, 12);
      end
      if ($urandom_range(0, 399) == 0) reset = 1'b1;
      else reset = 1'b0;
      step(1);
    end
    reset = 1'b0;
    step(20);

    // Exactly one expectation should be outstanding just after an edge.
    @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 1) n_pass++;
    else $display("FAIL scoreboard_drain got=%0d entries want=1", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
